mef_enchimento_lote: RTL

Parametrised successor to the single-bottle filling FSM. It sequences the conveyor motor and the fill valve for a batch of bottles: move bottle in, settle, fill until full, release.
It adds a fill timeout, a settle delay, a batch counter with batch-complete indication, and a latched alarm with cause and acknowledge.
It sits between the plant sensors (reservoir, bottle-present, full) and the actuator drivers.

---
 rtl/mef_enchimento_lote.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mef_enchimento_lote.sv
// Batch bottle-filling sequencer: conveyor motor and fill valve control with
// settle delay, fill timeout, batch counting and a latched, acknowledged alarm.
module mef_enchimento_lote #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned BATCH_SIZE    = 3,
    parameter int unsigned TIMER_W       = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned FILL_TIMEOUT  = 16
) (
    input  logic             CK,
    input  logic             nReset,
    input  logic             Start,
    input  logic             TemR,
    input  logic             TemG,
    input  logic             Cheia,
    input  logic             AckAlarme,
    output logic             Motor,
    output logic             Enchendo,
    output logic             Pronto,
    output logic             LoteCompleto,
    output logic             Alarme,
    output logic [1:0]       CausaAlarme,
    output logic [CNT_W-1:0] Contagem
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MOVE    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_FILL    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_BATCH   = 3'd5,
        ST_ALARM   = 3'd6
    } state_t;

    localparam logic [1:0]         CAUSA_NONE  = 2'b00;
    localparam logic [1:0]         CAUSA_RES   = 2'b01;
    localparam logic [1:0]         CAUSA_TMO   = 2'b10;
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FILL_LAST   = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   BATCH_CNT   = CNT_W'(BATCH_SIZE);

    state_t             r_state;
    state_t             w_next_state;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_next_timer;
    logic [CNT_W-1:0]   r_contagem;
    logic [CNT_W-1:0]   w_next_contagem;
    logic [1:0]         r_causa;
    logic [1:0]         w_next_causa;

    logic r_motor, r_enchendo, r_pronto, r_lote, r_alarme;
    logic w_motor, w_enchendo, w_pronto, w_lote, w_alarme;

    // State, timer, counter, cause and output flops; outputs load the decode of
    // the next state so they always match the state register.
    always_ff @(posedge CK or negedge nReset) begin
        if (!nReset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_contagem <= '0;
            r_causa    <= CAUSA_NONE;
            r_motor    <= 1'b0;
            r_enchendo <= 1'b0;
            r_pronto   <= 1'b0;
            r_lote     <= 1'b0;
            r_alarme   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_next_timer;
            r_contagem <= w_next_contagem;
            r_causa    <= w_next_causa;
            r_motor    <= w_motor;
            r_enchendo <= w_enchendo;
            r_pronto   <= w_pronto;
            r_lote     <= w_lote;
            r_alarme   <= w_alarme;
        end
    end

    // Next-state logic; reservoir loss outranks every other condition while active.
    always_comb begin
        w_next_state    = r_state;
        w_next_contagem = r_contagem;
        w_next_causa    = r_causa;
        unique case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    if (!TemR) begin
                        w_next_state = ST_ALARM;
                        w_next_causa = CAUSA_RES;
                    end else if (TemG) begin
                        w_next_state = ST_SETTLE;
                    end else begin
                        w_next_state = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                if (!TemR) begin
                    w_next_state = ST_ALARM;
                    w_next_causa = CAUSA_RES;
                end else if (!Start) begin
                    w_next_state = ST_IDLE;
                end else if (TemG) begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!TemR) begin
                    w_next_state = ST_ALARM;
                    w_next_causa = CAUSA_RES;
                end else if (!Start) begin
                    w_next_state = ST_IDLE;
                end else if (r_timer == SETTLE_LAST) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!TemR) begin
                    w_next_state = ST_ALARM;
                    w_next_causa = CAUSA_RES;
                end else if (!Start) begin
                    w_next_state = ST_IDLE;
                end else if (Cheia) begin
                    w_next_state = ST_RELEASE;
                    if (r_contagem < BATCH_CNT) begin
                        w_next_contagem = r_contagem + CNT_W'(1);
                    end
                end else if (r_timer == FILL_LAST) begin
                    w_next_state = ST_ALARM;
                    w_next_causa = CAUSA_TMO;
                end
            end
            ST_RELEASE: begin
                if (!TemR) begin
                    w_next_state = ST_ALARM;
                    w_next_causa = CAUSA_RES;
                end else if (!TemG) begin
                    if (r_contagem == BATCH_CNT) begin
                        w_next_state = ST_BATCH;
                    end else if (Start) begin
                        w_next_state = ST_MOVE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_BATCH: begin
                if (!Start) begin
                    w_next_state    = ST_IDLE;
                    w_next_contagem = '0;
                end
            end
            ST_ALARM: begin
                if (AckAlarme && TemR) begin
                    w_next_state = ST_IDLE;
                    w_next_causa = CAUSA_NONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Timer runs only while staying in SETTLE or FILL.
        w_next_timer = '0;
        if ((w_next_state == r_state) &&
            ((r_state == ST_SETTLE) || (r_state == ST_FILL))) begin
            w_next_timer = r_timer + TIMER_W'(1);
        end
    end

    // Moore output decode of the upcoming state.
    always_comb begin
        w_motor    = 1'b0;
        w_enchendo = 1'b0;
        w_pronto   = 1'b0;
        w_lote     = 1'b0;
        w_alarme   = 1'b0;
        unique case (w_next_state)
            ST_MOVE:    w_motor    = 1'b1;
            ST_FILL:    w_enchendo = 1'b1;
            ST_RELEASE: begin
                w_motor  = 1'b1;
                w_pronto = 1'b1;
            end
            ST_BATCH:   w_lote     = 1'b1;
            ST_ALARM:   w_alarme   = 1'b1;
            default:    w_motor    = 1'b0;
        endcase
    end

    assign Motor        = r_motor;
    assign Enchendo     = r_enchendo;
    assign Pronto       = r_pronto;
    assign LoteCompleto = r_lote;
    assign Alarme       = r_alarme;
    assign CausaAlarme  = r_causa;
    assign Contagem     = r_contagem;

endmodule
